// File: rtl/decode_writeback.sv
// Y86-64 decode/write-back: register-ID resolution, operand forwarding, 15x64 register file.
// IDs and operands are combinational (zero latency); writes commit on the rising clk edge.
module decode_writeback #(
  parameter logic [63:0] RSP_INIT = 64'd0,
  parameter logic [3:0]  RNONE    = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  d_icode,
  input  logic [3:0]  d_rA,
  input  logic [3:0]  d_rB,
  input  logic [63:0] d_valP,
  input  logic [3:0]  e_dstE,
  input  logic [63:0] e_valE,
  input  logic [3:0]  M_dstE,
  input  logic [63:0] M_valE,
  input  logic [3:0]  M_dstM,
  input  logic [63:0] m_valM,
  input  logic [3:0]  W_dstE,
  input  logic [63:0] W_valE,
  input  logic [3:0]  W_dstM,
  input  logic [63:0] W_valM,
  output logic [3:0]  d_srcA,
  output logic [3:0]  d_srcB,
  output logic [3:0]  d_dstE,
  output logic [3:0]  d_dstM,
  output logic [63:0] d_valA,
  output logic [63:0] d_valB
);

  localparam logic [3:0] RSP = 4'd4;

  logic [63:0] regFile [0:14];
  logic [63:0] rdA;
  logic [63:0] rdB;

  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    d_dstE = RNONE;
    d_dstM = RNONE;
    unique case (d_icode)
      4'h2: begin d_srcA = d_rA; d_dstE = d_rB; end
      4'h3: d_dstE = d_rB;
      4'h4: begin d_srcA = d_rA; d_srcB = d_rB; end
      4'h5: begin d_srcB = d_rB; d_dstM = d_rA; end
      4'h6: begin d_srcA = d_rA; d_srcB = d_rB; d_dstE = d_rB; end
      4'h8: begin d_srcB = RSP; d_dstE = RSP; end
      4'h9: begin d_srcA = RSP; d_srcB = RSP; d_dstE = RSP; end
      4'hA: begin d_srcA = d_rA; d_srcB = RSP; d_dstE = RSP; end
      4'hB: begin d_srcA = RSP; d_srcB = RSP; d_dstE = RSP; d_dstM = d_rA; end
      default: ;
    endcase
  end

  // RNONE has no backing entry; guard the index so it reads as zero.
  assign rdA = (d_srcA == RNONE) ? 64'd0 : regFile[d_srcA];
  assign rdB = (d_srcB == RNONE) ? 64'd0 : regFile[d_srcB];

  function automatic logic [63:0] fwd(input logic [3:0] src, input logic [63:0] rfVal);
    if (src == RNONE)       return 64'd0;
    else if (src == e_dstE) return e_valE;
    else if (src == M_dstM) return m_valM;
    else if (src == M_dstE) return M_valE;
    else if (src == W_dstM) return W_valM;
    else if (src == W_dstE) return W_valE;
    else                    return rfVal;
  endfunction

  always_comb begin
    d_valA = fwd(d_srcA, rdA);
    if (d_icode == 4'h7 || d_icode == 4'h8) d_valA = d_valP;
    d_valB = fwd(d_srcB, rdB);
  end

  // dstM is written last so it wins a same-register collision (popq %rsp).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) regFile[i] <= (i == 4) ? RSP_INIT : 64'd0;
    end else begin
      if (W_dstE != RNONE) regFile[W_dstE] <= W_valE;
      if (W_dstM != RNONE) regFile[W_dstM] <= W_valM;
    end
  end

endmodule

// File: tb/tb_decode_writeback.sv
// Directed-vector bench for decode_writeback with hand-computed expectations.
module tb_decode_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  d_icode, d_rA, d_rB;
  logic [63:0] d_valP;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [3:0]  d_srcA, d_srcB, d_dstE, d_dstM;
  logic [63:0] d_valA, d_valB;

  int nCompared = 0;
  int nMismatched = 0;
  logic [63:0] rv;

  decode_writeback #(.RSP_INIT(64'd200), .RNONE(4'hF)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_icode(d_icode), .d_rA(d_rA), .d_rB(d_rB), .d_valP(d_valP),
    .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstE(M_dstE), .M_valE(M_valE), .M_dstM(M_dstM), .m_valM(m_valM),
    .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_dstE(d_dstE), .d_dstM(d_dstM),
    .d_valA(d_valA), .d_valB(d_valB)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic idleFwd();
    e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
    e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;
  endtask

  // Read a register through rrmovq's srcA path with no forwarding active.
  task automatic readReg(input logic [3:0] r, output logic [63:0] v);
    idleFwd();
    d_icode = 4'h2; d_rA = r; d_rB = 4'h0;
    #1 v = d_valA;
  endtask

  task automatic doWrite(input logic [3:0] dE, input logic [63:0] vE,
                         input logic [3:0] dM, input logic [63:0] vM);
    @(negedge clk);
    idleFwd();
    W_dstE = dE; W_valE = vE; W_dstM = dM; W_valM = vM;
    @(posedge clk);
    #1 idleFwd();
  endtask

  initial begin
    rst_n = 1'b0;
    idleFwd();
    d_icode = 4'h1; d_rA = 4'h0; d_rB = 4'h0; d_valP = '0;
    #12;
    @(negedge clk) rst_n = 1'b1;

    // OPq rA=2 rB=3 after reset
    d_icode = 4'h6; d_rA = 4'h2; d_rB = 4'h3;
    #1;
    check("opq_srcA", d_srcA, 2);
    check("opq_srcB", d_srcB, 3);
    check("opq_dstE", d_dstE, 3);
    check("opq_dstM", d_dstM, 4'hF);
    check("opq_valA_rst", d_valA, 0);
    check("opq_valB_rst", d_valB, 0);
    readReg(4'h4, rv);
    check("rsp_init", rv, 200);

    // Same-cycle W forwarding before the write lands
    @(negedge clk);
    d_icode = 4'h6; d_rA = 4'h2; d_rB = 4'h2;
    W_dstE = 4'h2; W_valE = 64'd100;
    #1;
    check("w_fwd_A", d_valA, 100);
    check("w_fwd_B", d_valB, 100);
    @(posedge clk);
    #1 idleFwd();
    d_icode = 4'h6; d_rA = 4'h2; d_rB = 4'h3;
    #1 check("rf_reg2", d_valA, 100);

    // Forwarding priority chain
    e_dstE = 4'h2; e_valE = 64'd7;
    M_dstM = 4'h2; m_valM = 64'd8;
    M_dstE = 4'h2; M_valE = 64'd10;
    W_dstE = 4'h2; W_valE = 64'd9;
    #1 check("prio_e", d_valA, 7);
    e_dstE = 4'hF;
    #1 check("prio_Mm", d_valA, 8);
    M_dstM = 4'hF;
    #1 check("prio_ME", d_valA, 10);
    M_dstE = 4'hF;
    #1 check("prio_WE", d_valA, 9);
    W_dstM = 4'h2; W_valM = 64'd11;
    #1 check("prio_WM", d_valA, 11);

    // RNONE source never forwards
    idleFwd();
    d_icode = 4'h1; e_dstE = 4'hF; e_valE = 64'd55; W_dstE = 4'hF; W_valE = 64'd56;
    #1 check("rnone_valA", d_valA, 0);
    check("rnone_valB", d_valB, 0);

    // call / jXX take valP
    idleFwd();
    d_icode = 4'h8; d_valP = 64'd64;
    #1;
    check("call_valA", d_valA, 64);
    check("call_srcB", d_srcB, 4);
    check("call_dstE", d_dstE, 4);
    check("call_valB", d_valB, 200);
    d_icode = 4'h7;
    #1;
    check("jxx_valA", d_valA, 64);
    check("jxx_srcA", d_srcA, 4'hF);

    // dstE/dstM collision: valM wins
    doWrite(4'h4, 64'd5, 4'h4, 64'd6);
    readReg(4'h4, rv);
    check("popq_rsp_reg4", rv, 6);
    d_icode = 4'hB; d_rA = 4'h4;
    #1;
    check("popq_dstE", d_dstE, 4);
    check("popq_dstM", d_dstM, 4);
    check("popq_srcA", d_srcA, 4);

    // mrmovq and an undefined icode
    d_icode = 4'h5; d_rA = 4'h1; d_rB = 4'h7;
    #1;
    check("mrm_ids", {d_srcA, d_srcB, d_dstE, d_dstM}, 16'hF7F1);
    d_icode = 4'hD;
    #1 check("bad_ids", {d_srcA, d_srcB, d_dstE, d_dstM}, 16'hFFFF);

    // Async reset between edges, then a write blocked while held
    doWrite(4'h5, 64'd33, 4'hF, 64'd0);
    readReg(4'h5, rv);
    check("reg5_write", rv, 33);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    readReg(4'h5, rv);
    check("rst_reg5", rv, 0);
    readReg(4'h4, rv);
    check("rst_reg4", rv, 200);
    W_dstE = 4'h5; W_valE = 64'd77;
    @(posedge clk);
    #1 idleFwd();
    readReg(4'h5, rv);
    check("rst_blocks_wr", rv, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 readReg(4'h5, rv);
    check("post_rst_reg5", rv, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
